// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, opcodes, select constants and opcode classifiers
package mc_ctrl_pkg;
  typedef logic [5:0] op_t;
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;
  localparam op_t OP_AND = 6'd0, OP_OR = 6'd1, OP_ADD = 6'd2, OP_ADDI = 6'd3, OP_ANDI = 6'd4;
  localparam op_t OP_LW = 6'd5, OP_LWPOI = 6'd6, OP_SW = 6'd7;
  localparam op_t OP_BGT = 6'd8, OP_BLT = 6'd9, OP_BEQ = 6'd10, OP_BNE = 6'd11;
  localparam op_t OP_JMP = 6'd12, OP_CALL = 6'd13, OP_RET = 6'd14, OP_PUSH = 6'd15, OP_POP = 6'd16;
  localparam logic [1:0] PC_SRC_INC = 2'd0, PC_SRC_JMP = 2'd1, PC_SRC_BR = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1;
  function automatic logic is_rtype(op_t op);
    return op <= OP_ADD;
  endfunction
  function automatic logic is_imm(op_t op);
    return op == OP_ADDI || op == OP_ANDI;
  endfunction
  function automatic logic is_load(op_t op);
    return op == OP_LW || op == OP_LWPOI || op == OP_POP;
  endfunction
  function automatic logic is_store(op_t op);
    return op == OP_SW || op == OP_CALL || op == OP_PUSH;
  endfunction
  function automatic logic is_branch(op_t op);
    return op >= OP_BGT && op <= OP_BNE;
  endfunction
  function automatic logic is_stack(op_t op);
    return op >= OP_CALL && op <= OP_POP;
  endfunction
endpackage

// File: rtl/mc_branch_eval.sv
// mc_branch_eval: combinational taken decision for conditional branches
module mc_branch_eval
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_neg,
  output logic       o_taken
);
  always_comb begin
    o_taken = i_op == OP_BGT ? !i_carry :
              i_op == OP_BLT ? i_neg :
              i_op == OP_BEQ ? i_zero :
              i_op == OP_BNE && !i_zero;
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle IF/ID/EX/MEM/WB control unit with memory stalls and timeout.
// Define ILLEGAL_OP_TRAP_EN to trap undefined opcodes in TRAP instead of running them as NOPs.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                zero_flag,
  input  logic                carry_flag,
  input  logic                neg_flag,
  output logic [2:0]          state,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                j_src,
  output logic                ext_src,
  output logic                reg_des,
  output logic                alu_src,
  output logic [1:0]          wb_data,
  output logic                reg_w1,
  output logic                reg_w2,
  output logic                mem_read,
  output logic                mem_write,
  output logic                instr_done,
  output logic                mem_timeout
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic                illegal_op
`endif
);
  logic [2:0]          r_state, w_next;
  logic [OPCODE_W-1:0] r_op;
  logic [TO_CNT_W-1:0] r_cnt;
  logic                r_to;
  logic                w_legal, w_taken, w_stall, w_abort, w_ready, w_nop_done;
  logic [5:0]          w_op;
  // Illegal opcodes map onto 6'h3F so no classifier matches them.
  assign w_legal = ((r_op >> 6) == '0) && r_op[5:0] <= OP_POP;
  assign w_op    = w_legal ? r_op[5:0] : 6'h3F;
  assign w_ready = r_state == S_IF ? imem_ready : dmem_ready;
  assign w_stall = (r_state == S_IF || r_state == S_MEM) && !w_ready;
  assign w_abort = (MEM_TIMEOUT != 0) && w_stall && r_cnt == TO_CNT_W'(MEM_TIMEOUT - 1);
`ifdef ILLEGAL_OP_TRAP_EN
  assign w_nop_done = 1'b0;
  assign illegal_op = r_state == S_TRAP;
`else
  assign w_nop_done = !w_legal;
`endif
  mc_branch_eval u_br (.i_op(w_op), .i_zero(zero_flag), .i_carry(carry_flag), .i_neg(neg_flag), .o_taken(w_taken));
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:  w_next = imem_ready ? S_ID : S_IF;
`ifdef ILLEGAL_OP_TRAP_EN
      S_ID:  w_next = w_op == OP_JMP ? S_IF : w_legal ? S_EX : S_TRAP;
      S_TRAP: w_next = S_TRAP;
`else
      S_ID:  w_next = w_op == OP_JMP || !w_legal ? S_IF : S_EX;
`endif
      S_EX:  w_next = is_branch(w_op) ? S_IF : (is_rtype(w_op) || is_imm(w_op)) ? S_WB : S_MEM;
      S_MEM: w_next = dmem_ready ? (is_load(w_op) ? S_WB : S_IF) : w_abort ? S_IF : S_MEM;
      default: w_next = S_IF;
    endcase
  end
  always_comb begin
    state       = r_state;
    ir_write    = r_state == S_IF && imem_ready;
    pc_write    = ir_write || (r_state == S_ID && w_op == OP_JMP) || (r_state == S_EX && is_branch(w_op) && w_taken)
                  || (r_state == S_MEM && dmem_ready && (w_op == OP_CALL || w_op == OP_RET));
    pc_src      = !pc_write || r_state == S_IF ? PC_SRC_INC : r_state == S_EX ? PC_SRC_BR : PC_SRC_JMP;
    j_src       = r_state == S_MEM && dmem_ready && w_op == OP_RET;
    ext_src     = w_legal && !is_rtype(w_op);
    reg_des     = ext_src;
    alu_src     = ext_src;
    wb_data     = is_load(w_op) ? WB_MEM : WB_ALU;
    reg_w1      = r_state == S_WB && (w_op <= OP_LWPOI || w_op == OP_POP);
    reg_w2      = r_state == S_WB && w_op == OP_LWPOI;
    mem_read    = r_state == S_MEM && (is_load(w_op) || w_op == OP_RET);
    mem_write   = r_state == S_MEM && is_store(w_op);
    instr_done  = r_state == S_WB || (r_state == S_ID && (w_op == OP_JMP || w_nop_done))
                  || (r_state == S_EX && is_branch(w_op)) || (r_state == S_MEM && dmem_ready && !is_load(w_op));
    mem_timeout = r_to;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
      r_op    <= '0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (ir_write) r_op <= opcode;
      r_cnt <= w_stall && !w_abort ? r_cnt + TO_CNT_W'(1) : '0;
      if (w_abort) r_to <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed per-cycle vectors for mc_ctrl_fsm with MEM_TIMEOUT = 4
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;
  logic clk = 0, reset = 1;
  logic [5:0] opcode = '0;
  logic imem_ready = 0, dmem_ready = 0, zero_flag = 0, carry_flag = 0, neg_flag = 0;
  logic [2:0] state;
  logic [1:0] pc_src, wb_data;
  logic ir_write, pc_write, j_src, ext_src, reg_des, alu_src;
  logic reg_w1, reg_w2, mem_read, mem_write, instr_done, mem_timeout;
  logic [18:0] w_out;
  int n_chk = 0, n_err = 0;
`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_op;
`endif
  mc_ctrl_fsm #(.OPCODE_W(6), .MEM_TIMEOUT(4), .TO_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .neg_flag(neg_flag), .state(state),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .j_src(j_src), .ext_src(ext_src),
    .reg_des(reg_des), .alu_src(alu_src), .wb_data(wb_data), .reg_w1(reg_w1), .reg_w2(reg_w2),
    .mem_read(mem_read), .mem_write(mem_write), .instr_done(instr_done), .mem_timeout(mem_timeout)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );
  always #5 clk = ~clk;
  assign w_out = {state, ir_write, pc_write, pc_src, j_src, ext_src, reg_des, alu_src, wb_data,
                  reg_w1, reg_w2, mem_read, mem_write, instr_done, mem_timeout};
  function automatic logic [18:0] e(int st, ir, pw, ps, js, sel, wd, w1, w2, mr, mw, dn, to);
    return {3'(st), 1'(ir), 1'(pw), 2'(ps), 1'(js), {3{1'(sel)}}, 2'(wd), 1'(w1), 1'(w2), 1'(mr), 1'(mw), 1'(dn), 1'(to)};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [5:0] op, input logic im, dm, input logic [2:0] f, input logic [18:0] ex);
    opcode = op; imem_ready = im; dmem_ready = dm; {zero_flag, carry_flag, neg_flag} = f;
    #1 check(tag, 32'(w_out), 32'(ex));
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    cyc("rst", 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add_if", OP_ADD, 1, 0, 0, e(0,1,1,0,0,0,0,0,0,0,0,0,0));
    cyc("add_id", 0, 1, 0, 0, e(1,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add_ex", 0, 1, 0, 0, e(2,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add_wb", 0, 1, 0, 0, e(4,0,0,0,0,0,0,1,0,0,0,1,0));
    cyc("lw_if", OP_LW, 1, 0, 0, e(0,1,1,0,0,0,0,0,0,0,0,0,0));
    cyc("lw_id", 0, 1, 0, 0, e(1,0,0,0,0,1,1,0,0,0,0,0,0));
    cyc("lw_ex", 0, 1, 0, 0, e(2,0,0,0,0,1,1,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++) cyc("lw_stall", 0, 1, 0, 0, e(3,0,0,0,0,1,1,0,0,1,0,0,0));
    cyc("lw_mem", 0, 1, 1, 0, e(3,0,0,0,0,1,1,0,0,1,0,0,0));
    cyc("lw_wb", 0, 1, 0, 0, e(4,0,0,0,0,1,1,1,0,0,0,1,0));
    cyc("lwp_if", OP_LWPOI, 1, 0, 0, e(0,1,1,0,0,1,1,0,0,0,0,0,0));
    cyc("lwp_id", 0, 1, 0, 0, e(1,0,0,0,0,1,1,0,0,0,0,0,0));
    cyc("lwp_ex", 0, 1, 0, 0, e(2,0,0,0,0,1,1,0,0,0,0,0,0));
    cyc("lwp_mem", 0, 1, 1, 0, e(3,0,0,0,0,1,1,0,0,1,0,0,0));
    cyc("lwp_wb", 0, 1, 0, 0, e(4,0,0,0,0,1,1,1,1,0,0,1,0));
    cyc("beq1_if", OP_BEQ, 1, 0, 0, e(0,1,1,0,0,1,1,0,0,0,0,0,0));
    cyc("beq1_id", 0, 1, 0, 0, e(1,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("beq1_ex", 0, 1, 0, 3'b100, e(2,0,1,2,0,1,0,0,0,0,0,1,0));
    cyc("beq0_if", OP_BEQ, 1, 0, 0, e(0,1,1,0,0,1,0,0,0,0,0,0,0));
    cyc("beq0_id", 0, 1, 0, 3'b100, e(1,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("beq0_ex", 0, 1, 0, 3'b000, e(2,0,0,0,0,1,0,0,0,0,0,1,0));
    cyc("bgt_if", OP_BGT, 1, 0, 0, e(0,1,1,0,0,1,0,0,0,0,0,0,0));
    cyc("bgt_id", 0, 1, 0, 0, e(1,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("bgt_ex", 0, 1, 0, 3'b010, e(2,0,0,0,0,1,0,0,0,0,0,1,0));
    cyc("blt_if", OP_BLT, 1, 0, 0, e(0,1,1,0,0,1,0,0,0,0,0,0,0));
    cyc("blt_id", 0, 1, 0, 0, e(1,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("blt_ex", 0, 1, 0, 3'b001, e(2,0,1,2,0,1,0,0,0,0,0,1,0));
    cyc("call_if", OP_CALL, 1, 0, 0, e(0,1,1,0,0,1,0,0,0,0,0,0,0));
    cyc("call_id", 0, 1, 0, 0, e(1,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("call_ex", 0, 1, 0, 0, e(2,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("call_stall", 0, 1, 0, 0, e(3,0,0,0,0,1,0,0,0,0,1,0,0));
    cyc("call_mem", 0, 1, 1, 0, e(3,0,1,1,0,1,0,0,0,0,1,1,0));
    cyc("ret_if", OP_RET, 1, 0, 0, e(0,1,1,0,0,1,0,0,0,0,0,0,0));
    cyc("ret_id", 0, 1, 0, 0, e(1,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("ret_ex", 0, 1, 0, 0, e(2,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("ret_mem", 0, 1, 1, 0, e(3,0,1,1,1,1,0,0,0,1,0,1,0));
    cyc("jmp_if", OP_JMP, 1, 0, 0, e(0,1,1,0,0,1,0,0,0,0,0,0,0));
    cyc("jmp_id", 0, 1, 0, 0, e(1,0,1,1,0,1,0,0,0,0,0,1,0));
    cyc("sw_if", OP_SW, 1, 0, 0, e(0,1,1,0,0,1,0,0,0,0,0,0,0));
    cyc("sw_id", 0, 1, 0, 0, e(1,0,0,0,0,1,0,0,0,0,0,0,0));
    cyc("sw_ex", 0, 1, 0, 0, e(2,0,0,0,0,1,0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) cyc("sw_stall", 0, 1, 0, 0, e(3,0,0,0,0,1,0,0,0,0,1,0,0));
    cyc("sw_timeout", 0, 0, 0, 0, e(0,0,0,0,0,1,0,0,0,0,0,0,1));
    cyc("lw2_if", OP_LW, 1, 0, 0, e(0,1,1,0,0,1,0,0,0,0,0,0,1));
    cyc("lw2_id", 0, 1, 0, 0, e(1,0,0,0,0,1,1,0,0,0,0,0,1));
    cyc("lw2_ex", 0, 1, 0, 0, e(2,0,0,0,0,1,1,0,0,0,0,0,1));
    for (int i = 0; i < 2; i++) cyc("lw2_stall", 0, 1, 0, 0, e(3,0,0,0,0,1,1,0,0,1,0,0,1));
    reset = 1;
    @(negedge clk);
    reset = 0;
    cyc("rst_mid", 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("bad_if", 6'h3F, 1, 0, 0, e(0,1,1,0,0,0,0,0,0,0,0,0,0));
`ifdef ILLEGAL_OP_TRAP_EN
    cyc("bad_id", 0, 1, 1, 0, e(1,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++) begin
      #1 check("trap_flag", 32'(illegal_op), 32'd1);
      cyc("trap_hold", 0, 1, 1, 0, e(5,0,0,0,0,0,0,0,0,0,0,0,0));
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1 check("trap_rst_flag", 32'(illegal_op), 32'd0);
    cyc("trap_rst", 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0,0,0));
`else
    cyc("nop_id", 0, 1, 1, 0, e(1,0,0,0,0,0,0,0,0,0,0,1,0));
    cyc("nop_next", 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0,0,0));
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised successor to the current combinational control decoder: a multi-cycle control unit that owns the IF/ID/EX/MEM/WB state register itself.
- Adds ready/valid stalls toward instruction and data memory, and resolves branches in EX.
- Drives every datapath strobe of the multi-cycle CPU from registered state plus an opcode latched at fetch.
- Sits between the instruction register / memories and the datapath muxes, register file and PC.

Parameters:
- OPCODE_W, 6, opcode field width; encodings live in the package, and upper bits beyond 6 must be zero for legal ops.
- MEM_TIMEOUT, 0, maximum MEM/IF wait cycles before abort; 0 disables the timeout.
- TO_CNT_W, 8, width of the wait counter; must satisfy MEM_TIMEOUT < 2**TO_CNT_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  OPCODE_W  opcode field from instruction memory, sampled at fetch
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- zero_flag, carry_flag, neg_flag  in  1 each  ALU flags, valid during EX
- state  out  3  current state (IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5)
- ir_write  out  1  load instruction register
- pc_write  out  1  PC load strobe
- pc_src  out  2  0 = PC+1, 1 = jump/return target, 2 = branch target
- j_src  out  1  0 = immediate target, 1 = stack (RET)
- ext_src, reg_des, alu_src  out  1 each  datapath mux selects
- wb_data  out  2  0 = ALU, 1 = memory data
- reg_w1, reg_w2  out  1 each  register-file write enables (Rd, base register)
- mem_read, mem_write  out  1 each  data-memory request
- instr_done  out  1  one-cycle pulse on the instruction's final cycle
- mem_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset: state = IF, opcode_q = 0, wait counter = 0. Every output is 0 on the cycle after reset is sampled. Reset in any state, mid-stall included, aborts the instruction with no strobes.
- IF: ir_write, pc_write (pc_src = 0) and the opcode_q capture all occur in the same cycle that imem_ready = 1. That cycle transitions to ID; otherwise IF is held with all strobes 0.
- ID:
  - JMP → pc_write = 1, pc_src = 1, j_src = 0, instr_done = 1, next IF.
  - Any other legal op → EX.
- EX:
  - R-type (0–2), ADDI/ANDI (3–4) → WB.
  - LW (5), LWPOI (6), SW (7), CALL (13), RET (14), PUSH (15), POP (16) → MEM.
  - BGT (8, taken if carry = 0), BLT (9, neg = 1), BEQ (10, zero = 1), BNE (11, zero = 0) → IF with instr_done = 1. When taken, also pc_write = 1 and pc_src = 2; when not taken, pc_write = 0.
  - Flags are sampled only in the EX cycle.
- MEM:
  - mem_read is held for LW/LWPOI/RET/POP; mem_write is held for SW/CALL/PUSH. The request stays asserted until dmem_ready = 1.
  - On the dmem_ready cycle:
    - LW/LWPOI/POP → WB.
    - CALL/RET → pc_write = 1, pc_src = 1, j_src = (RET), instr_done, next IF.
    - SW/PUSH → instr_done, next IF.
- WB: reg_w1 = 1 for 0–6 and 16; reg_w2 = 1 for LWPOI only; instr_done = 1; next IF. Write enables are asserted only in WB.
- Mux selects are a function of opcode_q and stable from ID until instr_done:
  - R-type: reg_des = 0, alu_src = 0, ext_src = 0.
  - All immediate/memory/branch ops: reg_des = 1, alu_src = 1, ext_src = 1.
  - wb_data = 1 for LW/LWPOI/POP, 0 otherwise.
- Wait counter: increments each stalled cycle in IF or MEM and clears on ready.
  - With MEM_TIMEOUT > 0 and the count reaching MEM_TIMEOUT: mem_timeout is set, all requests drop, next IF, and no instr_done.
- Ready arriving in the first possible cycle gives zero stall. Minimum latencies: JMP 2, branch 3, ALU 4, LW 5 cycles.
- Opcodes 17..2**OPCODE_W-1: without the optional feature, treated as NOP (ID → IF with instr_done, no writes).

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an undefined opcode in ID → TRAP state (5). TRAP drives every strobe to 0, adds output illegal_op = 1, and holds until reset.
- Undefined: the TRAP state and the illegal_op port do not exist; undefined opcodes complete as a 2-cycle NOP.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_AND … OP_POP);
  - PC_SRC_* and WB_* select constants;
  - classification functions is_rtype, is_imm, is_load, is_store, is_branch, is_stack.
- One sub-module, mc_branch_eval: combinational taken-decision from opcode_q and the flags.

Test Plan:
- ADD with imem_ready = 1 always → states 0,1,2,4; reg_w1 = 1 only in cycle 4, wb_data = 0, instr_done on cycle 4.
- LW with dmem_ready low for 3 MEM cycles → mem_read held 4 cycles, then WB with reg_w1 = 1, wb_data = 1; LWPOI is the same with reg_w2 = 1.
- BEQ, zero = 1 → pc_write = 1, pc_src = 2 in EX. BEQ, zero = 0 → pc_write = 0. BGT with carry = 1 → not taken.
- CALL then RET → mem_write then mem_read in MEM; pc_write with j_src = 0 then j_src = 1.
- MEM_TIMEOUT = 4, dmem_ready stuck at 0 on SW → mem_write drops after 4 wait cycles, mem_timeout = 1, state = IF. Reset asserted mid-stall → all outputs 0, state = IF.
- Opcode 6'h3F → NOP in 2 cycles; with ILLEGAL_OP_TRAP_EN, state = 5 and illegal_op = 1 held until reset.
